// File: rtl/tictactoe_pkg.sv
// Shared encodings for the NxN tic-tac-toe controller: FSM state codes, cell
// contents and result codes, plus a small turn-handover helper.
package tictactoe_pkg;

  typedef enum logic [3:0] {
    MENU    = 4'd0,
    PLAYERS = 4'd1,
    ORDER   = 4'd2,
    TURN_P1 = 4'd3,
    TURN_P2 = 4'd4,
    CHECK   = 4'd5,
    OVER    = 4'd6
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_P1     = 2'b01;
  localparam logic [1:0] WIN_P2     = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  // The turn state belonging to the opponent of the player who just moved.
  function automatic state_t other_turn(input logic [1:0] mover);
    return (mover == CELL_P1) ? TURN_P2 : TURN_P1;
  endfunction

endpackage

// File: rtl/tictactoe_win_scan.sv
// Combinational K-in-a-row test for runs starting at one board cell, looking
// right, down, down-right and down-left; runs that would leave the board never match.
module tictactoe_win_scan
  import tictactoe_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [1:0]               board [N:1][N:1],
  input  logic [$clog2(N*N)-1:0]   idx,
  input  logic [1:0]               player,
  output logic                     match
);

  logic [N*N-1:0] hit;

  for (genvar gr = 1; gr <= N; gr++) begin : g_row
    for (genvar gc = 1; gc <= N; gc++) begin : g_col
      logic [3:0] dir_hit;
      for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        localparam int DR = (gd == 0) ? 0 : 1;
        localparam int DC = (gd == 0) ? 1 : (gd == 1) ? 0 : (gd == 2) ? 1 : -1;
        localparam int ER = gr + DR * (K - 1);
        localparam int EC = gc + DC * (K - 1);
        // Only directions whose last stone lands on the board are built at all.
        if (ER <= N && EC >= 1 && EC <= N) begin : g_in
          logic [K-1:0] eq;
          for (genvar gj = 0; gj < K; gj++) begin : g_run
            assign eq[gj] = (board[gr + DR * gj][gc + DC * gj] == player);
          end
          assign dir_hit[gd] = &eq;
        end else begin : g_out
          assign dir_hit[gd] = 1'b0;
        end
      end
      assign hit[(gr - 1) * N + gc - 1] = |dir_hit;
    end
  end

  assign match = hit[idx];

endmodule

// File: rtl/tictactoe_nxn.sv
// NxN K-in-a-row game controller: menu FSM, button edge detection, cursor,
// turn timer with auto-move, optional machine opponent and a serial win scan.
module tictactoe_nxn
  import tictactoe_pkg::*;
#(
  parameter int N           = 3,
  parameter int K           = 3,
  parameter int TURN_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     select,
  input  logic                     move,
  input  logic                     orden,
  input  logic                     cant_player,
  output logic [1:0]               board [N:1][N:1],
  output logic [1:0]               winner,
  output logic [3:0]               estado,
  output logic [$clog2(N*N)-1:0]   cursor
);

  localparam int CELLS = N * N;
  localparam int IW    = $clog2(CELLS);
  localparam int MW    = $clog2(CELLS + 1);
  localparam int TW    = $clog2(TURN_CYCLES + 1);

  state_t          state_r, state_nx;
  logic            sel_d_r, mov_d_r, humans_r;
  logic [MW-1:0]   moves_r;
  logic [TW-1:0]   timer_r;
  logic [IW-1:0]   scan_idx_r;
  logic [1:0]      mover_r;

  logic            sel_edge_s, mov_edge_s, in_turn_s, machine_s, match_s;
  logic [CELLS-1:0] occ_s;
  logic [IW-1:0]   low_empty_s, place_idx_s;
  logic [1:0]      cur_code_s;
  logic            place_s, adv_s, clear_s, latch_players_s, win_s, draw_s;

  assign sel_edge_s = select & ~sel_d_r;
  assign mov_edge_s = move & ~mov_d_r;
  assign in_turn_s  = (state_r == TURN_P1) || (state_r == TURN_P2);
  assign machine_s  = (state_r == TURN_P2) && !humans_r;
  assign cur_code_s = (state_r == TURN_P2) ? CELL_P2 : CELL_P1;
  assign estado     = state_r;

  for (genvar gr = 1; gr <= N; gr++) begin : g_occ_row
    for (genvar gc = 1; gc <= N; gc++) begin : g_occ_col
      assign occ_s[(gr - 1) * N + gc - 1] = (board[gr][gc] != CELL_EMPTY);
    end
  end

  // Priority encoder: lowest-index empty cell, used by auto and machine moves.
  always_comb begin
    low_empty_s = {IW{1'b0}};
    for (int i = CELLS - 1; i >= 0; i--) begin
      low_empty_s = occ_s[i] ? low_empty_s : IW'(i);
    end
  end

  tictactoe_win_scan #(.N(N), .K(K)) u_scan (
    .board  (board),
    .idx    (scan_idx_r),
    .player (mover_r),
    .match  (match_s)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx        = state_r;
    place_s         = 1'b0;
    place_idx_s     = cursor;
    adv_s           = 1'b0;
    clear_s         = 1'b0;
    latch_players_s = 1'b0;
    win_s           = 1'b0;
    draw_s          = 1'b0;
    case (state_r)
      MENU: begin
        if (sel_edge_s) state_nx = PLAYERS;
        else            state_nx = MENU;
      end
      PLAYERS: begin
        if (sel_edge_s) begin
          latch_players_s = 1'b1;
          state_nx        = ORDER;
        end else begin
          state_nx = PLAYERS;
        end
      end
      ORDER: begin
        // orden is consumed here; the chosen TURN state is its latched form.
        if (sel_edge_s) state_nx = orden ? TURN_P2 : TURN_P1;
        else            state_nx = ORDER;
      end
      TURN_P1, TURN_P2: begin
        if (machine_s) begin
          if (timer_r == TW'(1)) begin
            place_s     = 1'b1;
            place_idx_s = low_empty_s;
          end else begin
            place_s = 1'b0;
          end
        end else if (sel_edge_s && !occ_s[cursor]) begin
          place_s     = 1'b1;
          place_idx_s = cursor;
        end else if (timer_r == TW'(TURN_CYCLES - 1)) begin
          place_s     = 1'b1;
          place_idx_s = low_empty_s;
        end else begin
          // A select in the same cycle pins the cursor, even when it is ignored.
          adv_s = mov_edge_s && !sel_edge_s;
        end
        if (place_s) state_nx = CHECK;
        else         state_nx = state_r;
      end
      CHECK: begin
        if (match_s) begin
          win_s    = 1'b1;
          state_nx = OVER;
        end else if (scan_idx_r == IW'(CELLS - 1)) begin
          if (moves_r == MW'(CELLS)) begin
            draw_s   = 1'b1;
            state_nx = OVER;
          end else begin
            state_nx = other_turn(mover_r);
          end
        end else begin
          state_nx = CHECK;
        end
      end
      OVER: begin
        if (sel_edge_s) begin
          clear_s  = 1'b1;
          state_nx = MENU;
        end else begin
          state_nx = OVER;
        end
      end
      default: state_nx = MENU;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= MENU;
    else     state_r <= state_nx;
  end

  // Button history, game mode, cursor, timer, move counter and scan pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_d_r    <= 1'b0;
      mov_d_r    <= 1'b0;
      humans_r   <= 1'b0;
      cursor     <= {IW{1'b0}};
      timer_r    <= {TW{1'b0}};
      moves_r    <= {MW{1'b0}};
      scan_idx_r <= {IW{1'b0}};
      mover_r    <= CELL_EMPTY;
      winner     <= WIN_NONE;
    end else begin
      sel_d_r <= select;
      mov_d_r <= move;
      if (latch_players_s) humans_r <= cant_player;
      if (clear_s)         cursor <= {IW{1'b0}};
      else if (adv_s)      cursor <= (cursor == IW'(CELLS - 1)) ? {IW{1'b0}} : cursor + IW'(1);
      timer_r <= in_turn_s ? timer_r + TW'(1) : {TW{1'b0}};
      if (clear_s)         moves_r <= {MW{1'b0}};
      else if (place_s)    moves_r <= moves_r + MW'(1);
      if (place_s) begin
        mover_r    <= cur_code_s;
        scan_idx_r <= {IW{1'b0}};
      end else if (state_r == CHECK) begin
        scan_idx_r <= scan_idx_r + IW'(1);
      end
      if (clear_s)         winner <= WIN_NONE;
      else if (win_s)      winner <= mover_r;
      else if (draw_s)     winner <= WIN_DRAW;
    end
  end

  // Board storage: single-cell writes on placement, bulk clear on leaving OVER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r <= N; r++) begin
        for (int c = 1; c <= N; c++) begin
          board[r][c] <= CELL_EMPTY;
        end
      end
    end else begin
      for (int r = 1; r <= N; r++) begin
        for (int c = 1; c <= N; c++) begin
          if (clear_s)
            board[r][c] <= CELL_EMPTY;
          else if (place_s && place_idx_s == IW'((r - 1) * N + c - 1))
            board[r][c] <= cur_code_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_tictactoe_nxn.sv
// Scoreboard bench for tictactoe_nxn: a 3x3/K3/TURN_CYCLES=20 instance and a 5x5/K4 instance
// share stimulus; a negedge monitor checks every placement and result against queued expectations.
module tb_tictactoe_nxn;

  logic clk = 1'b0;
  logic rst = 1'b1, select = 1'b0, move = 1'b0, orden = 1'b0, cant_player = 1'b0;

  logic [1:0] board_a [3:1][3:1];
  logic [1:0] winner_a;
  logic [3:0] estado_a, cursor_a;
  logic [1:0] board_b [5:1][5:1];
  logic [1:0] winner_b;
  logic [3:0] estado_b;
  logic [4:0] cursor_b;

  tictactoe_nxn #(.N(3), .K(3), .TURN_CYCLES(20)) ua (
    .clk(clk), .rst(rst), .select(select), .move(move), .orden(orden),
    .cant_player(cant_player), .board(board_a), .winner(winner_a),
    .estado(estado_a), .cursor(cursor_a));

  tictactoe_nxn #(.N(5), .K(4), .TURN_CYCLES(1000)) ub (
    .clk(clk), .rst(rst), .select(select), .move(move), .orden(orden),
    .cant_player(cant_player), .board(board_b), .winner(winner_b),
    .estado(estado_b), .cursor(cursor_b));

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [1:0] fa [0:8];
  logic [1:0] fb [0:24];
  for (genvar r = 1; r <= 3; r++) begin : g_fa_r
    for (genvar c = 1; c <= 3; c++) begin : g_fa_c
      assign fa[(r - 1) * 3 + c - 1] = board_a[r][c];
    end
  end
  for (genvar r = 1; r <= 5; r++) begin : g_fb_r
    for (genvar c = 1; c <= 5; c++) begin : g_fb_c
      assign fb[(r - 1) * 5 + c - 1] = board_b[r][c];
    end
  end

  logic act = 1'b0;  // 0 observes the 3x3 instance, 1 the 5x5 instance

  typedef struct { int kind; int idx; int val; int cyc; } exp_t;  // kind 0 place, 1 result
  exp_t sb_q[$];
  int tests = 0, fails = 0;

  function automatic int cur_estado();
    return act ? int'(estado_b) : int'(estado_a);
  endfunction
  function automatic int cur_winner();
    return act ? int'(winner_b) : int'(winner_a);
  endfunction
  function automatic int cur_cursor();
    return act ? int'(cursor_b) : int'(cursor_a);
  endfunction
  function automatic int nonempty();
    int n = 0;
    for (int i = 0; i < 25; i++) begin
      if (act && fb[i] != 2'b00) n++;
      if (!act && i < 9 && fa[i] != 2'b00) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc_cnt);
    end
  endtask

  task automatic expect_place(input int idx, input int val, input int cyc);
    exp_t e;
    e = '{0, idx, val, cyc};
    sb_q.push_back(e);
  endtask
  task automatic expect_result(input int val, input int cyc);
    exp_t e;
    e = '{1, 0, val, cyc};
    sb_q.push_back(e);
  endtask

  // Monitor: every new stone or new result is popped against the scoreboard.
  logic [1:0] prev [0:24];
  logic [1:0] prevw = 2'b00;
  logic [1:0] cur;
  initial begin
    for (int i = 0; i < 25; i++) prev[i] = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < (act ? 25 : 9); i++) begin
        if (act) cur = fb[i];
        else     cur = fa[i];
        if (cur != prev[i] && cur != 2'b00) sb_compare(0, i, int'(cur));
        prev[i] = cur;
      end
      cur = act ? winner_b : winner_a;
      if (cur != prevw && cur != 2'b00) sb_compare(1, 0, int'(cur));
      prevw = cur;
    end
  end

  task automatic sb_compare(input int kind, input int idx, input int val);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got kind=%0d idx=%0d val=%0d at cycle %0d, want no event",
               kind, idx, val, cyc_cnt);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.val != val || (e.cyc >= 0 && e.cyc != cyc_cnt)) begin
        fails++;
        $display("FAIL sb_event: got kind=%0d idx=%0d val=%0d cycle=%0d, want kind=%0d idx=%0d val=%0d cycle=%0d",
                 kind, idx, val, cyc_cnt, e.kind, e.idx, e.val, e.cyc);
      end
    end
  endtask

  task automatic pulse_sel();
    select = 1'b1; @(negedge clk); select = 1'b0; @(negedge clk);
  endtask
  task automatic pulse_both();
    select = 1'b1; move = 1'b1; @(negedge clk); select = 1'b0; move = 1'b0; @(negedge clk);
  endtask
  task automatic moves(input int n);
    for (int i = 0; i < n; i++) begin
      move = 1'b1; @(negedge clk); move = 1'b0; @(negedge clk);
    end
  endtask

  task automatic wait_estado(input int code, input int limit);
    int n = 0;
    while (cur_estado() != code && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_estado", cur_estado(), code);
  endtask
  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  task automatic do_reset(input logic which);
    rst = 1'b1; select = 1'b0; move = 1'b0; act = which;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic menu_to_order(input logic humans, input logic ord);
    cant_player = humans; orden = ord;
    check("estado_menu", cur_estado(), 0);
    pulse_sel();
    check("estado_players", cur_estado(), 1);
    pulse_sel();
    check("estado_order", cur_estado(), 2);
  endtask

  // One human turn: walk the cursor, then select an empty cell.
  task automatic turn(input int steps, input int idx, input int val);
    wait_estado(val == 1 ? 3 : 4, 40);
    moves(steps);
    expect_place(idx, val, cyc_cnt + 1);
    pulse_sel();
  endtask

  initial begin
    int t;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state of the 3x3 instance
    do_reset(1'b0);
    check("reset_estado", cur_estado(), 0);
    check("reset_winner", cur_winner(), 0);
    check("reset_cursor", cur_cursor(), 0);
    check("reset_board", nonempty(), 0);

    // Two humans, P1 first: row 0 win; first select coincides with a move edge
    menu_to_order(1'b1, 1'b0);
    pulse_sel();
    check("estado_turn_p1", cur_estado(), 3);
    expect_place(0, 1, cyc_cnt + 1);
    pulse_both();
    check("cursor_after_move_and_select", cur_cursor(), 0);
    turn(3, 3, 2);
    turn(7, 1, 1);
    turn(3, 4, 2);
    wait_estado(3, 40);
    moves(7);
    t = cyc_cnt;
    expect_place(2, 1, t + 1);
    expect_result(1, t + 2);
    pulse_sel();
    wait_drain(20);
    check("estado_over_win", cur_estado(), 6);
    pulse_sel();
    check("over_clear_estado", cur_estado(), 0);
    check("over_clear_winner", cur_winner(), 0);
    check("over_clear_cursor", cur_cursor(), 0);
    check("over_clear_board", nonempty(), 0);

    // Full-board draw: X O X / X O O / O X X
    menu_to_order(1'b1, 1'b0);
    pulse_sel();
    turn(0, 0, 1);
    turn(1, 1, 2);
    turn(1, 2, 1);
    turn(2, 4, 2);
    turn(8, 3, 1);
    turn(2, 5, 2);
    turn(2, 7, 1);
    turn(8, 6, 2);
    wait_estado(3, 40);
    moves(2);
    t = cyc_cnt;
    expect_place(8, 1, t + 1);
    expect_result(3, t + 10);
    pulse_sel();
    wait_drain(30);
    check("estado_over_draw", cur_estado(), 6);

    // Machine opponent moving first, ignored select, and turn timeouts
    do_reset(1'b0);
    menu_to_order(1'b0, 1'b1);
    t = cyc_cnt;
    expect_place(0, 2, t + 3);
    pulse_sel();
    check("estado_turn_p2_machine", cur_estado(), 4);
    wait_estado(3, 40);
    t = cyc_cnt;
    expect_place(1, 1, t + 20);
    pulse_sel();
    wait_drain(40);
    wait_estado(4, 40);
    expect_place(2, 2, cyc_cnt + 2);
    wait_drain(10);
    wait_estado(3, 40);
    expect_place(3, 1, cyc_cnt + 20);
    wait_drain(40);

    // Asynchronous reset in the middle of CHECK
    check("estado_in_check", cur_estado(), 5);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_check_estado", cur_estado(), 0);
    check("rst_mid_check_board", nonempty(), 0);
    check("rst_mid_check_winner", cur_winner(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post_rst_board", nonempty(), 0);
    check("post_rst_estado", cur_estado(), 0);

    // 5x5, K=4: P2 down-left diagonal from [1][4]; 3-long runs must not win
    do_reset(1'b1);
    menu_to_order(1'b1, 1'b1);
    pulse_sel();
    turn(3, 3, 2);
    turn(22, 0, 1);
    turn(7, 7, 2);
    turn(19, 1, 1);
    turn(10, 11, 2);
    turn(16, 2, 1);
    wait_estado(4, 40);
    moves(13);
    t = cyc_cnt;
    expect_place(15, 2, t + 1);
    expect_result(2, t + 5);
    pulse_sel();
    wait_drain(40);
    check("estado_over_5x5", cur_estado(), 6);
    check("winner_5x5", cur_winner(), 2);

    repeat (3) @(negedge clk);
    check("scoreboard_empty_at_end", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
